// File: rtl/screen_writer_if.sv
// rtl/screen_writer_if.sv - CPU/renderer/RAM bundle for screen_writer (clear ports with SCREEN_WRITER_CLEAR_EN)
interface screen_writer_if #(
    parameter int FIFO_DEPTH_LOG2 = 3
);
    logic [15:0]              cpu_addr;
    logic [7:0]               cpu_data;
    logic                     cpu_we;
    logic                     cpu_stall;
    logic                     screen_read_en;
    logic                     ram_we;
    logic [10:0]              ram_waddr;
    logic [7:0]               ram_wdata;
    logic [FIFO_DEPTH_LOG2:0] fifo_level;
    logic                     overflow;
`ifdef SCREEN_WRITER_CLEAR_EN
    logic                     clear_req;
    logic [7:0]               clear_color;
    logic                     clear_busy;

    modport slave (
        input  cpu_addr, cpu_data, cpu_we, screen_read_en, clear_req, clear_color,
        output cpu_stall, ram_we, ram_waddr, ram_wdata, fifo_level, overflow, clear_busy
    );
    modport master (
        output cpu_addr, cpu_data, cpu_we, screen_read_en, clear_req, clear_color,
        input  cpu_stall, ram_we, ram_waddr, ram_wdata, fifo_level, overflow, clear_busy
    );
`else
    modport slave (
        input  cpu_addr, cpu_data, cpu_we, screen_read_en,
        output cpu_stall, ram_we, ram_waddr, ram_wdata, fifo_level, overflow
    );
    modport master (
        output cpu_addr, cpu_data, cpu_we, screen_read_en,
        input  cpu_stall, ram_we, ram_waddr, ram_wdata, fifo_level, overflow
    );
`endif
endinterface

// File: rtl/screen_writer.sv
// rtl/screen_writer.sv - queues CPU screen-window writes and drains them while the renderer is idle
// Optional full-screen clear engine is built when SCREEN_WRITER_CLEAR_EN is defined.
module screen_writer #(
    parameter int          FIFO_DEPTH_LOG2 = 3,
    parameter logic [15:0] BASE_ADDR       = 16'h0200
) (
    input  logic          clk,
    input  logic          reset,
    screen_writer_if.slave bus
);
    localparam int                     DEPTH      = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] FULL_LEVEL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
    // 17-bit end so a window touching 0xFFFF does not wrap.
    localparam logic [16:0]            WIN_END    = {1'b0, BASE_ADDR} + 17'd1024;

    logic [18:0]                mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [FIFO_DEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [FIFO_DEPTH_LOG2:0]   level_q, level_d;
    logic                       overflow_q, overflow_d;
    logic                       ram_we_q, ram_we_d;
    logic [10:0]                ram_waddr_q, ram_waddr_d;
    logic [7:0]                 ram_wdata_q, ram_wdata_d;

    logic in_window, full, empty, pop, push;
    logic clear_active, clr_we;
    logic [10:0] clr_addr;
    logic [7:0]  clr_data;

`ifdef SCREEN_WRITER_CLEAR_EN
    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
    state_t     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic [7:0] color_q, color_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            color_q <= color_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        color_d = color_q;
        clr_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.clear_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    color_d = bus.clear_color;
                end
            end
            ST_CLEAR: begin
                // The clear yields to the renderer exactly like the FIFO drain.
                if (!bus.screen_read_en) begin
                    clr_we = 1'b1;
                    cnt_d  = cnt_q + 10'd1;
                    if (cnt_q == 10'h3FF) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign clear_active   = (state_q == ST_CLEAR);
    assign clr_addr       = 11'h200 + {1'b0, cnt_q};
    assign clr_data       = color_q;
    assign bus.clear_busy = clear_active;
`else
    assign clear_active = 1'b0;
    assign clr_we       = 1'b0;
    assign clr_addr     = '0;
    assign clr_data     = '0;
`endif

    assign in_window = bus.cpu_we && (bus.cpu_addr >= BASE_ADDR) && ({1'b0, bus.cpu_addr} < WIN_END);
    assign full      = (level_q == FULL_LEVEL);
    assign empty     = (level_q == '0);
    assign pop       = !empty && !bus.screen_read_en && !clear_active;
    // A full FIFO still accepts a write when the same edge frees a slot.
    assign push      = in_window && (!full || pop);

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        ram_we_d    = 1'b0;
        ram_waddr_d = ram_waddr_q;
        ram_wdata_d = ram_wdata_q;

        if (push) wptr_d = wptr_q + 1'b1;
        if (pop)  rptr_d = rptr_q + 1'b1;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (in_window && !push) overflow_d = 1'b1;

        if (clr_we) begin
            ram_we_d    = 1'b1;
            ram_waddr_d = clr_addr;
            ram_wdata_d = clr_data;
        end else if (pop) begin
            ram_we_d    = 1'b1;
            ram_waddr_d = mem[rptr_q][18:8];
            ram_wdata_d = mem[rptr_q][7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_waddr_q <= '0;
            ram_wdata_q <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            ram_we_q    <= ram_we_d;
            ram_waddr_q <= ram_waddr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wptr_q] <= {bus.cpu_addr[10:0], bus.cpu_data};
    end

    assign bus.cpu_stall  = full;
    assign bus.fifo_level = level_q;
    assign bus.overflow   = overflow_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.ram_waddr  = ram_waddr_q;
    assign bus.ram_wdata  = ram_wdata_q;
endmodule

// File: tb/tb_screen_writer.sv
// tb/tb_screen_writer.sv - vector table, corner sequences and randomized queue-model check for screen_writer
module tb_screen_writer;
    localparam int L     = 3;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    screen_writer_if #(.FIFO_DEPTH_LOG2(L)) sw_if ();
    screen_writer #(.FIFO_DEPTH_LOG2(L), .BASE_ADDR(16'h0200)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sw_if)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue of {addr[10:0], data}.
    logic [18:0] mq[$];
    logic        m_we;
    logic [10:0] m_addr;
    logic [7:0]  m_data;
    logic        m_ovf;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        sre;
        logic        e_we;
        logic [10:0] e_addr;
        logic [7:0]  e_data;
        logic [3:0]  e_lvl;
        logic        e_stall;
        logic        e_ovf;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_we = 1'b0; m_addr = '0; m_data = '0; m_ovf = 1'b0;
    endfunction

    function automatic void model_step(input logic we, input logic [15:0] addr,
                                       input logic [7:0] data, input logic sre);
        logic        inwin;
        logic        was_full;
        logic        pop;
        logic [18:0] ent;
        inwin    = we && (addr >= 16'h0200) && (addr < 16'h0600);
        was_full = (mq.size() == DEPTH);
        pop      = (mq.size() > 0) && !sre;
        m_we     = pop;
        if (pop) begin
            ent    = mq.pop_front();
            m_addr = ent[18:8];
            m_data = ent[7:0];
        end
        if (inwin) begin
            if (!was_full || pop) mq.push_back({addr[10:0], data});
            else                  m_ovf = 1'b1;
        end
    endfunction

    task automatic drive_edge(input logic we, input logic [15:0] addr,
                              input logic [7:0] data, input logic sre);
        @(negedge clk);
        sw_if.cpu_we         = we;
        sw_if.cpu_addr       = addr;
        sw_if.cpu_data       = data;
        sw_if.screen_read_en = sre;
        model_step(we, addr, data, sre);
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, "_ram_we"}, 32'(sw_if.ram_we), 32'(m_we));
        chk({tag, "_waddr"},  32'(sw_if.ram_waddr), 32'(m_addr));
        chk({tag, "_wdata"},  32'(sw_if.ram_wdata), 32'(m_data));
        chk({tag, "_level"},  32'(sw_if.fifo_level), 32'(mq.size()));
        chk({tag, "_stall"},  32'(sw_if.cpu_stall), 32'(mq.size() == DEPTH));
        chk({tag, "_ovf"},    32'(sw_if.overflow), 32'(m_ovf));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset                = 1'b0;
        sw_if.cpu_we         = 1'b0;
        sw_if.cpu_addr       = '0;
        sw_if.cpu_data       = '0;
        sw_if.screen_read_en = 1'b0;
        #2;
        model_reset();
        chk({tag, "_rst_we"},    32'(sw_if.ram_we), 0);
        chk({tag, "_rst_waddr"}, 32'(sw_if.ram_waddr), 0);
        chk({tag, "_rst_wdata"}, 32'(sw_if.ram_wdata), 0);
        chk({tag, "_rst_level"}, 32'(sw_if.fifo_level), 0);
        chk({tag, "_rst_stall"}, 32'(sw_if.cpu_stall), 0);
        chk({tag, "_rst_ovf"},   32'(sw_if.overflow), 0);
`ifdef SCREEN_WRITER_CLEAR_EN
        chk({tag, "_rst_busy"},  32'(sw_if.clear_busy), 0);
`endif
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        sw_if.cpu_we = 1'b0; sw_if.cpu_addr = '0; sw_if.cpu_data = '0; sw_if.screen_read_en = 1'b0;
`ifdef SCREEN_WRITER_CLEAR_EN
        sw_if.clear_req = 1'b0; sw_if.clear_color = '0;
`endif
        do_reset("init");

        // Single write, out-of-window writes, small busy-renderer burst.
        tbl[0]  = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 11'h000, 8'h00, 4'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 16'h0234, 8'h05, 1'b0, 1'b0, 11'h000, 8'h00, 4'd1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 11'h234, 8'h05, 4'd0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 11'h234, 8'h05, 4'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 16'h01FF, 8'h99, 1'b0, 1'b0, 11'h234, 8'h05, 4'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 16'h0600, 8'h98, 1'b0, 1'b0, 11'h234, 8'h05, 4'd0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 16'h0200, 8'hAA, 1'b1, 1'b0, 11'h234, 8'h05, 4'd1, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 16'h05FF, 8'hBB, 1'b1, 1'b0, 11'h234, 8'h05, 4'd2, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 11'h200, 8'hAA, 4'd1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 16'h0300, 8'h11, 1'b0, 1'b1, 11'h5FF, 8'hBB, 4'd1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 11'h300, 8'h11, 4'd0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 11'h300, 8'h11, 4'd0, 1'b0, 1'b0};
        for (int i = 0; i < 12; i++) begin
            drive_edge(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].sre);
            chk($sformatf("tbl%0d_we", i),    32'(sw_if.ram_we),     32'(tbl[i].e_we));
            chk($sformatf("tbl%0d_waddr", i), 32'(sw_if.ram_waddr),  32'(tbl[i].e_addr));
            chk($sformatf("tbl%0d_wdata", i), 32'(sw_if.ram_wdata),  32'(tbl[i].e_data));
            chk($sformatf("tbl%0d_level", i), 32'(sw_if.fifo_level), 32'(tbl[i].e_lvl));
            chk($sformatf("tbl%0d_stall", i), 32'(sw_if.cpu_stall),  32'(tbl[i].e_stall));
            chk($sformatf("tbl%0d_ovf", i),   32'(sw_if.overflow),   32'(tbl[i].e_ovf));
        end

        // Fill while renderer busy, overflow, then ordered drain.
        do_reset("fill");
        for (int i = 0; i < 8; i++) drive_edge(1'b1, 16'h0400 + 16'(i), 8'hA0 + 8'(i), 1'b1);
        chk("fill_level", 32'(sw_if.fifo_level), 8);
        chk("fill_stall", 32'(sw_if.cpu_stall), 1);
        chk("fill_ovf0",  32'(sw_if.overflow), 0);
        drive_edge(1'b1, 16'h0480, 8'hFF, 1'b1);
        chk("fill_ovf1",   32'(sw_if.overflow), 1);
        chk("fill_level9", 32'(sw_if.fifo_level), 8);
        for (int i = 0; i < 8; i++) begin
            drive_edge(1'b0, 16'h0000, 8'h00, 1'b0);
            chk($sformatf("drain%0d_we", i),    32'(sw_if.ram_we), 1);
            chk($sformatf("drain%0d_waddr", i), 32'(sw_if.ram_waddr), 32'h400 + i);
            chk($sformatf("drain%0d_wdata", i), 32'(sw_if.ram_wdata), 32'hA0 + i);
            if (i == 0) chk("drain_stall_fall", 32'(sw_if.cpu_stall), 0);
        end
        drive_edge(1'b0, 16'h0000, 8'h00, 1'b0);
        chk("drain_done_we",  32'(sw_if.ram_we), 0);
        chk("drain_done_lvl", 32'(sw_if.fifo_level), 0);
        chk("drain_ovf_sticky", 32'(sw_if.overflow), 1);

        // Push and pop on the same edge while full.
        do_reset("pp");
        for (int i = 0; i < 8; i++) drive_edge(1'b1, 16'h0400 + 16'(i), 8'(i), 1'b1);
        drive_edge(1'b1, 16'h0500, 8'h5A, 1'b0);
        chk("pp_level", 32'(sw_if.fifo_level), 8);
        chk("pp_ovf",   32'(sw_if.overflow), 0);
        chk("pp_we",    32'(sw_if.ram_we), 1);
        chk("pp_waddr", 32'(sw_if.ram_waddr), 32'h400);
        for (int i = 0; i < 8; i++) drive_edge(1'b0, 16'h0000, 8'h00, 1'b0);
        chk("pp_last_waddr", 32'(sw_if.ram_waddr), 32'h500);
        chk("pp_last_wdata", 32'(sw_if.ram_wdata), 32'h5A);

        // Renderer rises mid-drain: no further writes while it holds the RAM.
        do_reset("mid");
        for (int i = 0; i < 4; i++) drive_edge(1'b1, 16'h0410 + 16'(i), 8'h30 + 8'(i), 1'b1);
        drive_edge(1'b0, 16'h0000, 8'h00, 1'b0);
        chk("mid_first_we", 32'(sw_if.ram_we), 1);
        for (int i = 0; i < 3; i++) begin
            drive_edge(1'b0, 16'h0000, 8'h00, 1'b1);
            chk($sformatf("mid_hold%0d_we", i),  32'(sw_if.ram_we), 0);
            chk($sformatf("mid_hold%0d_lvl", i), 32'(sw_if.fifo_level), 3);
        end
        drive_edge(1'b0, 16'h0000, 8'h00, 1'b0);
        chk("mid_resume_waddr", 32'(sw_if.ram_waddr), 32'h411);

        // Randomized traffic against the queue model, with one reset mid-run.
        do_reset("rnd");
        for (int cyc = 0; cyc < 500; cyc++) begin
            logic        we;
            logic [15:0] addr;
            logic        sre;
            we = ($urandom_range(0, 9) < 6);
            case ($urandom_range(0, 7))
                0:       addr = 16'h01FF;
                1:       addr = 16'h0600;
                2:       addr = 16'h0200;
                3:       addr = 16'h05FF;
                4:       addr = 16'($urandom);
                default: addr = 16'h0200 + 16'($urandom_range(0, 1023));
            endcase
            sre = ($urandom_range(0, 99) < ((cyc % 64) < 24 ? 90 : 10));
            if (cyc == 250) do_reset("rnd_mid");
            drive_edge(we, addr, 8'($urandom), sre);
            cmp_model($sformatf("rnd%0d", cyc));
        end

`ifdef SCREEN_WRITER_CLEAR_EN
        begin
            int nclr;
            int bad;
            bit got_cpu;
            do_reset("clr");
            @(negedge clk);
            sw_if.clear_req = 1'b1; sw_if.clear_color = 8'h0E;
            @(posedge clk); #1;
            chk("clr_busy_rise", 32'(sw_if.clear_busy), 1);
            @(negedge clk);
            sw_if.clear_req = 1'b0;
            nclr = 0; bad = 0; got_cpu = 1'b0;
            for (int cyc = 0; cyc < 3000 && !got_cpu; cyc++) begin
                sw_if.screen_read_en = ((cyc % 9) == 8);
                sw_if.cpu_we   = (cyc == 100);
                sw_if.cpu_addr = 16'h0345;
                sw_if.cpu_data = 8'h77;
                sw_if.clear_req   = (cyc == 200);
                sw_if.clear_color = 8'h33;
                @(posedge clk); #1;
                if (sw_if.ram_we) begin
                    if (nclr < 1024) begin
                        if (sw_if.ram_waddr !== 11'(32'h200 + nclr) || sw_if.ram_wdata !== 8'h0E) bad++;
                        nclr++;
                    end else begin
                        got_cpu = 1'b1;
                        chk("clr_cpu_waddr", 32'(sw_if.ram_waddr), 32'h345);
                        chk("clr_cpu_wdata", 32'(sw_if.ram_wdata), 32'h77);
                    end
                end
                @(negedge clk);
            end
            sw_if.cpu_we = 1'b0; sw_if.clear_req = 1'b0; sw_if.screen_read_en = 1'b0;
            chk("clr_count",   32'(nclr), 1024);
            chk("clr_bad",     32'(bad), 0);
            chk("clr_got_cpu", 32'(got_cpu), 1);
            chk("clr_busy_fall", 32'(sw_if.clear_busy), 0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
